// File: rtl/prco_wb_lsu_pkg.sv
// Shared definitions for the prco writeback / load-store unit:
// FSM state encoding, prco ISA opcode values, the status-register index
// and a helper that classifies opcodes writing their destination register.
package prco_wb_lsu_pkg;

    localparam int unsigned OP_W   = 5;
    // Register-file index that CMP writes its flags into.
    localparam int unsigned REG_SR = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MEM   = 3'd1,
        ST_WB    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } lsu_state_e;

    // prco ISA opcodes
    localparam logic [OP_W-1:0] PRCO_OP_NOP  = 5'h00;
    localparam logic [OP_W-1:0] PRCO_OP_MOV  = 5'h01;
    localparam logic [OP_W-1:0] PRCO_OP_MOVI = 5'h02;
    localparam logic [OP_W-1:0] PRCO_OP_ADD  = 5'h03;
    localparam logic [OP_W-1:0] PRCO_OP_ADDI = 5'h04;
    localparam logic [OP_W-1:0] PRCO_OP_SUBI = 5'h05;
    localparam logic [OP_W-1:0] PRCO_OP_OR   = 5'h06;
    localparam logic [OP_W-1:0] PRCO_OP_XOR  = 5'h07;
    localparam logic [OP_W-1:0] PRCO_OP_AND  = 5'h08;
    localparam logic [OP_W-1:0] PRCO_OP_CMP  = 5'h09;
    localparam logic [OP_W-1:0] PRCO_OP_JMP  = 5'h0A;
    localparam logic [OP_W-1:0] PRCO_OP_LW   = 5'h0B;
    localparam logic [OP_W-1:0] PRCO_OP_SW   = 5'h0C;

    // Opcodes whose result (or load data) lands in the destination register.
    function automatic logic writes_dst(input logic [OP_W-1:0] op);
        logic w;
        case (op)
            PRCO_OP_LW, PRCO_OP_MOV, PRCO_OP_MOVI, PRCO_OP_ADD, PRCO_OP_ADDI,
            PRCO_OP_SUBI, PRCO_OP_OR, PRCO_OP_XOR, PRCO_OP_AND: w = 1'b1;
            default:                                            w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prco_wb_lsu_mem_tmo.sv
// Memory-ack timeout counter: cleared when a request starts, counts each
// un-acked request cycle, flags terminal count on the cycle whose increment
// would reach TIMEOUT.
// Ports: i_clk/i_rst_n clock and async reset, i_clr clear, i_en count enable,
//        tc_c combinational terminal-count flag.
module prco_wb_lsu_mem_tmo #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic tc_c
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    assign tc_c = (cnt_q == TMO_W'(TIMEOUT - 1));

    // Counter next value
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !tc_c) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prco_wb_lsu.sv
// prco execute back end: takes the ALU's registered result, performs LW/SW
// over a req/ack data-memory port, writes back to the register file, SR or
// PC, then pulses fetch-enable to restart the pipeline.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_ce_reg, i_ce_ram             ALU result ready for writeback / memory
//   i_op, i_result, i_should_branch, i_dst, i_store_data   ALU payload
//   q_mem_req/we/addr/wdata, i_mem_ack, i_mem_rdata         data-memory port
//   q_reg_we/waddr/wdata           register-file write port
//   q_pc_we, q_pc                  PC load
//   q_ce_fetch                     instruction retired pulse
//   q_busy, q_fault                not idle / sticky memory timeout
module prco_wb_lsu
    import prco_wb_lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce_reg,
    input  logic              i_ce_ram,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_should_branch,
    input  logic [REG_AW-1:0] i_dst,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              q_mem_req,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [DATA_W-1:0] q_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              q_reg_we,
    output logic [REG_AW-1:0] q_reg_waddr,
    output logic [DATA_W-1:0] q_reg_wdata,
    output logic              q_pc_we,
    output logic [DATA_W-1:0] q_pc,
    output logic              q_ce_fetch,
    output logic              q_busy,
    output logic              q_fault
);

    lsu_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;       // ALU result or load data
    logic              branch_q, branch_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              reg_we_q, reg_we_d;
    logic [REG_AW-1:0] reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              pc_we_q, pc_we_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              ce_fetch_q, ce_fetch_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;

    logic              tmo_clr;
    logic              tmo_en;
    logic              tmo_tc;

    prco_wb_lsu_mem_tmo #(
        .TMO_W   (TMO_W),
        .TIMEOUT (TIMEOUT)
    ) u_mem_tmo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmo_clr),
        .i_en    (tmo_en),
        .tc_c    (tmo_tc)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        data_d      = data_q;
        branch_d    = branch_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        pc_we_d     = 1'b0;
        pc_d        = pc_q;
        ce_fetch_d  = 1'b0;
        fault_d     = fault_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Memory path has priority when both enables arrive together.
                if (i_ce_ram) begin
                    mem_addr_d  = i_result[ADDR_W-1:0];
                    mem_wdata_d = i_store_data;
                    mem_we_d    = (i_op == PRCO_OP_SW);
                    mem_req_d   = 1'b1;
                    op_d        = i_op;
                    dst_d       = i_dst;
                    tmo_clr     = 1'b1;
                    state_d     = ST_MEM;
                end else if (i_ce_reg) begin
                    op_d     = i_op;
                    data_d   = i_result;
                    dst_d    = i_dst;
                    branch_d = i_should_branch;
                    state_d  = ST_WB;
                end
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    if (op_q == PRCO_OP_LW) begin
                        data_d  = i_mem_rdata;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_tc) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = ST_FAULT;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ST_WB: begin
                if (writes_dst(op_q)) begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = dst_q;
                    reg_wdata_d = data_q;
                end else if (op_q == PRCO_OP_CMP) begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = REG_AW'(REG_SR);
                    reg_wdata_d = data_q;
                end else if (op_q == PRCO_OP_JMP) begin
                    pc_we_d = branch_q;
                    pc_d    = data_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ce_fetch_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            branch_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            pc_we_q     <= 1'b0;
            pc_q        <= '0;
            ce_fetch_q  <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            branch_q    <= branch_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            pc_we_q     <= pc_we_d;
            pc_q        <= pc_d;
            ce_fetch_q  <= ce_fetch_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    assign q_mem_req   = mem_req_q;
    assign q_mem_we    = mem_we_q;
    assign q_mem_addr  = mem_addr_q;
    assign q_mem_wdata = mem_wdata_q;
    assign q_reg_we    = reg_we_q;
    assign q_reg_waddr = reg_waddr_q;
    assign q_reg_wdata = reg_wdata_q;
    assign q_pc_we     = pc_we_q;
    assign q_pc        = pc_q;
    assign q_ce_fetch  = ce_fetch_q;
    assign q_busy      = busy_q;
    assign q_fault     = fault_q;

endmodule
